// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, control encodings and the control half
// of the ID/EX pipeline register.
package decode_pkg;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Width-independent controls; the XLEN-wide data fields sit beside it in the top.
    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic [2:0] alu_control;
        logic       alu_src;
        logic       valid;
        logic       illegal;
    } id_ex_t;

endpackage

// File: rtl/decode_ctrl.sv
// Main decoder: opcode/funct3/funct7 to datapath controls, immediate format
// and illegal-instruction flag. Purely combinational.
module decode_ctrl
    import decode_pkg::*;
(
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic       mem_write,
    output logic       branch,
    output logic       jump,
    output logic [2:0] alu_control,
    output logic       alu_src,
    output logic [1:0] imm_src,
    output logic       illegal
);

    logic [2:0] alu_fn;

    // op[5] separates R-type from I-type, so addi never turns into a subtract.
    always_comb begin
        alu_fn = ALU_ADD;
        case (funct3)
            3'b000:  alu_fn = (op[5] && funct7_5) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_fn = ALU_SLT;
            3'b110:  alu_fn = ALU_OR;
            3'b111:  alu_fn = ALU_AND;
            default: alu_fn = ALU_ADD;
        endcase
    end

    always_comb begin
        reg_write   = 1'b0;
        result_src  = RES_ALU;
        mem_write   = 1'b0;
        branch      = 1'b0;
        jump        = 1'b0;
        alu_control = ALU_ADD;
        alu_src     = 1'b0;
        imm_src     = IMM_I;
        illegal     = 1'b0;
        case (op)
            OP_LW: begin
                reg_write  = 1'b1;
                result_src = RES_MEM;
                alu_src    = 1'b1;
            end
            OP_SW: begin
                mem_write = 1'b1;
                alu_src   = 1'b1;
                imm_src   = IMM_S;
            end
            OP_R: begin
                reg_write   = 1'b1;
                alu_control = alu_fn;
            end
            OP_I: begin
                reg_write   = 1'b1;
                alu_src     = 1'b1;
                alu_control = alu_fn;
            end
            OP_BEQ: begin
                branch      = 1'b1;
                alu_control = ALU_SUB;
                imm_src     = IMM_B;
            end
            OP_JAL: begin
                reg_write  = 1'b1;
                jump       = 1'b1;
                result_src = RES_PC4;
                imm_src    = IMM_J;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/decode_stage_hz.sv
// RISC-V decode stage with register file, ID/EX register and load-use stall.
// Define RF_WRITE_BYPASS_EN to make register-file reads see a same-cycle writeback.
module decode_stage_hz
    import decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    localparam int REG_AW = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instr_d,
    input  logic [XLEN-1:0]   pc_d,
    input  logic [XLEN-1:0]   pc_plus4_d,
    input  logic [REG_AW-1:0] rd_w,
    input  logic [XLEN-1:0]   result_w,
    input  logic              reg_write_w,
    input  logic              flush_e,
    output logic              stall_f,
    output logic              stall_d,
    output logic              reg_write_e,
    output logic              mem_write_e,
    output logic              branch_e,
    output logic              jump_e,
    output logic              alu_src_e,
    output logic              valid_e,
    output logic              illegal_e,
    output logic [1:0]        result_src_e,
    output logic [2:0]        alu_control_e,
    output logic [XLEN-1:0]   rd1_e,
    output logic [XLEN-1:0]   rd2_e,
    output logic [XLEN-1:0]   imm_ext_e,
    output logic [XLEN-1:0]   pc_e,
    output logic [XLEN-1:0]   pc_plus4_e,
    output logic [REG_AW-1:0] rs1_e,
    output logic [REG_AW-1:0] rs2_e,
    output logic [REG_AW-1:0] rd_e
);

    logic [REG_AW-1:0] rs1_d, rs2_d, rd_d;
    logic [XLEN-1:0]   rd1_d, rd2_d, imm_ext_d;
    logic [1:0]        imm_src_d;
    logic              lw_stall;
    id_ex_t            ctl_d, ctl_q;
    logic [XLEN-1:0]   rf [NREG];

    assign rs1_d = REG_AW'(instr_d[19:15]);
    assign rs2_d = REG_AW'(instr_d[24:20]);
    assign rd_d  = REG_AW'(instr_d[11:7]);

    decode_ctrl u_ctrl (
        .op          (instr_d[6:0]),
        .funct3      (instr_d[14:12]),
        .funct7_5    (instr_d[30]),
        .reg_write   (ctl_d.reg_write),
        .result_src  (ctl_d.result_src),
        .mem_write   (ctl_d.mem_write),
        .branch      (ctl_d.branch),
        .jump        (ctl_d.jump),
        .alu_control (ctl_d.alu_control),
        .alu_src     (ctl_d.alu_src),
        .imm_src     (imm_src_d),
        .illegal     (ctl_d.illegal)
    );
    assign ctl_d.valid = 1'b1;

    // Register file contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (reg_write_w && rd_w != '0) rf[rd_w] <= result_w;
    end

`ifdef RF_WRITE_BYPASS_EN
    assign rd1_d = (rs1_d == '0) ? '0 : (reg_write_w && rd_w == rs1_d) ? result_w : rf[rs1_d];
    assign rd2_d = (rs2_d == '0) ? '0 : (reg_write_w && rd_w == rs2_d) ? result_w : rf[rs2_d];
`else
    assign rd1_d = (rs1_d == '0) ? '0 : rf[rs1_d];
    assign rd2_d = (rs2_d == '0) ? '0 : rf[rs2_d];
`endif

    always_comb begin
        imm_ext_d = '0;
        case (imm_src_d)
            IMM_I: imm_ext_d = {{(XLEN-12){instr_d[31]}}, instr_d[31:20]};
            IMM_S: imm_ext_d = {{(XLEN-12){instr_d[31]}}, instr_d[31:25], instr_d[11:7]};
            IMM_B: imm_ext_d = {{(XLEN-13){instr_d[31]}}, instr_d[31], instr_d[7],
                                instr_d[30:25], instr_d[11:8], 1'b0};
            IMM_J: imm_ext_d = {{(XLEN-21){instr_d[31]}}, instr_d[31], instr_d[19:12],
                                instr_d[20], instr_d[30:21], 1'b0};
            default: imm_ext_d = '0;
        endcase
    end

    // Source fields are compared regardless of format; a spurious stall only costs a cycle.
    assign lw_stall = (result_src_e == RES_MEM) && valid_e && (rd_e != '0) &&
                      ((rd_e == rs1_d) || (rd_e == rs2_d));
    assign stall_f  = lw_stall;
    assign stall_d  = lw_stall;

    // A bubble is exactly the reset image of the register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctl_q      <= '0;
            rd1_e      <= '0;
            rd2_e      <= '0;
            imm_ext_e  <= '0;
            pc_e       <= '0;
            pc_plus4_e <= '0;
            rs1_e      <= '0;
            rs2_e      <= '0;
            rd_e       <= '0;
        end else if (flush_e || lw_stall) begin
            ctl_q      <= '0;
            rd1_e      <= '0;
            rd2_e      <= '0;
            imm_ext_e  <= '0;
            pc_e       <= '0;
            pc_plus4_e <= '0;
            rs1_e      <= '0;
            rs2_e      <= '0;
            rd_e       <= '0;
        end else begin
            ctl_q      <= ctl_d;
            rd1_e      <= rd1_d;
            rd2_e      <= rd2_d;
            imm_ext_e  <= imm_ext_d;
            pc_e       <= pc_d;
            pc_plus4_e <= pc_plus4_d;
            rs1_e      <= rs1_d;
            rs2_e      <= rs2_d;
            rd_e       <= rd_d;
        end
    end

    assign reg_write_e   = ctl_q.reg_write;
    assign result_src_e  = ctl_q.result_src;
    assign mem_write_e   = ctl_q.mem_write;
    assign branch_e      = ctl_q.branch;
    assign jump_e        = ctl_q.jump;
    assign alu_control_e = ctl_q.alu_control;
    assign alu_src_e     = ctl_q.alu_src;
    assign valid_e       = ctl_q.valid;
    assign illegal_e     = ctl_q.illegal;

endmodule

// File: tb/tb_decode_stage_hz.sv
// Randomised bench for decode_stage_hz: a mnemonic-level model predicts the
// E-stage image and stall per cycle; monitors pop and compare.
module tb_decode_stage_hz;

    typedef struct packed {
        logic        reg_write;
        logic [1:0]  result_src;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic [2:0]  alu_control;
        logic        alu_src;
        logic        valid;
        logic        illegal;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } e_t;
    localparam int EW = $bits(e_t);

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] instr_d = 32'h13;
    logic [31:0] pc_d = '0, pc_plus4_d = '0, result_w = '0;
    logic [4:0]  rd_w = '0;
    logic        reg_write_w = 1'b0, flush_e = 1'b0;
    logic        stall_f, stall_d, reg_write_e, mem_write_e, branch_e, jump_e;
    logic        alu_src_e, valid_e, illegal_e;
    logic [1:0]  result_src_e;
    logic [2:0]  alu_control_e;
    logic [31:0] rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e;
    logic [4:0]  rs1_e, rs2_e, rd_e;

    always #5 clk = ~clk;

    decode_stage_hz #(.XLEN(32), .NREG(32)) dut (
        .clk(clk), .rst(rst), .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
        .rd_w(rd_w), .result_w(result_w), .reg_write_w(reg_write_w), .flush_e(flush_e),
        .stall_f(stall_f), .stall_d(stall_d), .reg_write_e(reg_write_e),
        .mem_write_e(mem_write_e), .branch_e(branch_e), .jump_e(jump_e),
        .alu_src_e(alu_src_e), .valid_e(valid_e), .illegal_e(illegal_e),
        .result_src_e(result_src_e), .alu_control_e(alu_control_e), .rd1_e(rd1_e),
        .rd2_e(rd2_e), .imm_ext_e(imm_ext_e), .pc_e(pc_e), .pc_plus4_e(pc_plus4_e),
        .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e)
    );

    e_t act;
    assign act = {reg_write_e, result_src_e, mem_write_e, branch_e, jump_e, alu_control_e,
                  alu_src_e, valid_e, illegal_e, rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e,
                  rs1_e, rs2_e, rd_e};

    // Scoreboard state
    logic [EW-1:0] exp_q[$];
    logic          stall_q[$];
    int            n_checks = 0;
    int            n_fail = 0;
    logic [31:0]   rf_m [32];
    e_t            model_e = '0;
    logic          last_stall = 1'b0;
    logic [31:0]   held_instr = 32'h13;

    task automatic check(input string name, input logic [EW-1:0] got, input logic [EW-1:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
`ifdef RF_WRITE_BYPASS_EN
        if (reg_write_w && rd_w == idx) return result_w;
`endif
        return rf_m[idx];
    endfunction

    // R/I arithmetic by mnemonic: add/sub, slt, or, and
    function automatic logic [2:0] model_alu(input logic [2:0] f3, input logic is_sub);
        case (f3)
            3'b000:  return is_sub ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic e_t model_decode(input logic [31:0] ins, input logic [31:0] pc);
        e_t e = '0;
        logic [31:0] imm_i = 32'($signed(ins[31:20]));
        e.valid = 1'b1;
        e.imm   = imm_i;
        case (ins[6:0])
            7'h03: begin e.reg_write = 1; e.result_src = 2'b01; e.alu_src = 1; end
            7'h23: begin
                e.mem_write = 1; e.alu_src = 1;
                e.imm = 32'($signed({ins[31:25], ins[11:7]}));
            end
            7'h33: begin e.reg_write = 1; e.alu_control = model_alu(ins[14:12], ins[30]); end
            7'h13: begin e.reg_write = 1; e.alu_src = 1; e.alu_control = model_alu(ins[14:12], 1'b0); end
            7'h63: begin
                e.branch = 1; e.alu_control = 3'b001;
                e.imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            end
            7'h6f: begin
                e.reg_write = 1; e.jump = 1; e.result_src = 2'b10;
                e.imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
            end
            default: e.illegal = 1;
        endcase
        e.rd1 = model_read(ins[19:15]);
        e.rd2 = model_read(ins[24:20]);
        e.pc  = pc;
        e.pc4 = pc + 32'd4;
        e.rs1 = ins[19:15];
        e.rs2 = ins[24:20];
        e.rd  = ins[11:7];
        return e;
    endfunction

    task automatic drive_cycle(input logic [31:0] ins, input logic fl, input logic wen,
                               input logic [4:0] wrd, input logic [31:0] wdata, input logic do_rst);
        e_t   nxt;
        logic exp_stall;
        @(negedge clk);
        rst         = 1'b1;
        instr_d     = ins;
        pc_d        = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
        pc_plus4_d  = pc_d + 32'd4;
        flush_e     = fl;
        reg_write_w = wen;
        rd_w        = wrd;
        result_w    = wdata;
        // Stall iff the valid instruction now in E is a load writing a source of D
        exp_stall = model_e.valid && model_e.result_src == 2'b01 && model_e.rd != 5'd0 &&
                    (model_e.rd == ins[19:15] || model_e.rd == ins[24:20]);
        stall_q.push_back(exp_stall);
        if (do_rst || fl || exp_stall) nxt = '0;
        else nxt = model_decode(ins, pc_d);
        if (wen && wrd != 5'd0) rf_m[wrd] = wdata;
        model_e = nxt;
        exp_q.push_back(nxt);
        last_stall = exp_stall;
        held_instr = ins;
        if (do_rst) begin
            #2 rst = 1'b0;
            #1 check("async_rst", act, '0);
        end
    endtask

    function automatic logic [31:0] gen_instr();
        logic [31:0] r = $urandom;
        logic [4:0]  rd = 5'($urandom_range(0, 7));
        logic [4:0]  rs1 = 5'($urandom_range(0, 7));
        logic [4:0]  rs2 = 5'($urandom_range(0, 7));
        logic [2:0]  f3;
        logic [6:0]  op;
        case ($urandom_range(0, 3))
            0: f3 = 3'b000;
            1: f3 = 3'b010;
            2: f3 = 3'b110;
            default: f3 = 3'b111;
        endcase
        case ($urandom_range(0, 6))
            0: return {r[11:0], rs1, 3'b010, rd, 7'h03};
            1: return {r[6:0], rs2, rs1, 3'b010, r[11:7], 7'h23};
            2: return {((f3 == 3'b000 && r[31]) ? 7'h20 : 7'h00), rs2, rs1, f3, rd, 7'h33};
            3: return {r[11:0], rs1, f3, rd, 7'h13};
            4: return {r[6:0], rs2, rs1, 3'b000, r[11:7], 7'h63};
            5: return {r[19:0], rd, 7'h6f};
            default: begin
                op = 7'($urandom_range(0, 127));
                while (op == 7'h03 || op == 7'h23 || op == 7'h33 || op == 7'h13 ||
                       op == 7'h63 || op == 7'h6f) op = 7'($urandom_range(0, 127));
                return {r[24:0], op};
            end
        endcase
    endfunction

    // Monitors: E image after each active edge, stall mid-cycle
    logic [EW-1:0] mon_e;
    logic          mon_s;
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("e_regs", act, mon_e);
        end
    end
    always @(negedge clk) begin
        #1;
        if (stall_q.size() > 0) begin
            mon_s = stall_q.pop_front();
            check("stall_f", EW'(stall_f), EW'(mon_s));
            check("stall_d", EW'(stall_d), EW'(mon_s));
        end
    end

    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [31:0] ADD_3_1_2 = 32'h0020_81B3;
    localparam logic [31:0] LW_5_8_1  = 32'h0080_A283;
    localparam logic [31:0] ADD_6_5_2 = 32'h0022_8333;
    localparam logic [31:0] LW_0_0_1  = 32'h0000_A003;
    localparam logic [31:0] ADD_6_0_2 = 32'h0020_0333;
    localparam logic [31:0] ADD_7_4_0 = 32'h0002_03B3;
    localparam logic [31:0] ADD_8_0_0 = 32'h0000_0433;
    localparam logic [31:0] BEQ_M8    = 32'hFE20_8CE3;
    localparam logic [31:0] ILL_7F    = 32'h0000_007F;

    initial begin
        logic [31:0] init_v;
        logic [31:0] ins;
        repeat (2) @(negedge clk);
        #1;
        check("reset_e", act, '0);
        check("reset_stall", EW'(stall_f), '0);

        for (int i = 1; i < 32; i++) begin
            init_v = (i == 1) ? 32'd5 : (i == 2) ? 32'd7 : (i == 4) ? 32'h1111_1111 : $urandom;
            drive_cycle(NOP, 0, 1, 5'(i), init_v, 0);
        end

        drive_cycle(ADD_3_1_2, 0, 0, 0, 0, 0);
        drive_cycle(LW_5_8_1, 0, 0, 0, 0, 0);
        drive_cycle(ADD_6_5_2, 0, 0, 0, 0, 0);
        drive_cycle(ADD_6_5_2, 0, 0, 0, 0, 0);
        drive_cycle(LW_0_0_1, 0, 0, 0, 0, 0);
        drive_cycle(ADD_6_0_2, 0, 0, 0, 0, 0);
        drive_cycle(LW_5_8_1, 0, 0, 0, 0, 0);
        drive_cycle(ADD_6_5_2, 1, 0, 0, 0, 0);
        drive_cycle(ADD_6_5_2, 0, 0, 0, 0, 0);
        drive_cycle(ADD_7_4_0, 0, 1, 5'd4, 32'hDEAD_BEEF, 0);
        drive_cycle(ADD_8_0_0, 0, 1, 5'd0, 32'h1234_5678, 0);
        drive_cycle(ADD_8_0_0, 0, 0, 0, 0, 0);
        drive_cycle(BEQ_M8, 0, 0, 0, 0, 0);
        drive_cycle(ILL_7F, 0, 0, 0, 0, 0);
        drive_cycle(LW_5_8_1, 0, 0, 0, 0, 0);
        drive_cycle(ADD_6_5_2, 0, 0, 0, 0, 1);
        drive_cycle(ADD_6_5_2, 0, 0, 0, 0, 0);

        for (int n = 0; n < 600; n++) begin
            ins = last_stall ? held_instr : gen_instr();
            drive_cycle(ins, ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
                        5'($urandom_range(0, 7)), $urandom, (n == 300));
        end

        repeat (2) @(negedge clk);
        #2;
        check("queue_drain", EW'(exp_q.size() + stall_q.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
